// File: rtl/muldiv_arbiter.sv
// Round-robin front end for the shared mul/div unit: grants one requester,
// captures its op, sequences the unit with a completion watchdog, returns a one-cycle response.
module muldiv_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [8*NUM_REQ-1:0]    req_op_i,
  input  logic [32*NUM_REQ-1:0]   req_op1_i,
  input  logic [32*NUM_REQ-1:0]   req_op2_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  output logic [31:0]             resp_data_o,
  output logic                    resp_err_o,
  output logic [31:0]             unit_op1_o,
  output logic [31:0]             unit_op2_o,
  output logic [7:0]              unit_op_o,
  input  logic [31:0]             unit_wdata_i,
  input  logic                    unit_we_i
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int CAW = IW + 1;
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, grant_idx, grant_q;
  logic            grant_found, accept;
  logic [CAW-1:0]  cand;
  logic [7:0]      op_q;
  logic [31:0]     op1_q, op2_q, data_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic            op_legal, timeout_hit;

  assign op_legal    = (op_q != 8'h00) && ((op_q & (op_q - 8'd1)) == 8'h00);
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Search starts just after the last granted index and wraps once.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = CAW'(ptr) + CAW'(1) + CAW'(i);
      if (cand >= CAW'(NUM_REQ)) cand = cand - CAW'(NUM_REQ);
      if (!grant_found && req_valid_i[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (!op_legal || unit_we_i || timeout_hit) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Illegal ops pass through one BUSY cycle with the unit lines held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      grant_q <= '0;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op_i[8*grant_idx +: 8];
        op1_q   <= req_op1_i[32*grant_idx +: 32];
        op2_q   <= req_op2_i[32*grant_idx +: 32];
        grant_q <= grant_idx;
        ptr     <= grant_idx;
        cnt     <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        if (!op_legal) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else if (unit_we_i) begin
          data_q <= unit_wdata_i;
          err_q  <= 1'b0;
        end else if (timeout_hit) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_data_o  = '0;
    resp_err_o   = 1'b0;
    unit_op_o    = '0;
    unit_op1_o   = '0;
    unit_op2_o   = '0;
    if (accept) req_ready_o = NUM_REQ'(1) << grant_idx;
    if (state == BUSY && op_legal) begin
      unit_op_o  = op_q;
      unit_op1_o = op1_q;
      unit_op2_o = op2_q;
    end
    if (state == RESP) begin
      resp_valid_o = NUM_REQ'(1) << grant_q;
      resp_data_o  = data_q;
      resp_err_o   = err_q;
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: vector table plus hand sequences for
// reset-in-flight and spurious unit completions; the bench plays the unit.
module tb_muldiv_arbiter;
  localparam int N  = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid_i, req_ready_o, resp_valid_o;
  logic [8*N-1:0]  req_op_i;
  logic [32*N-1:0] req_op1_i, req_op2_i;
  logic [31:0]   resp_data_o, unit_op1_o, unit_op2_o, unit_wdata_i;
  logic          resp_err_o, unit_we_i;
  logic [7:0]    unit_op_o;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {grant, err, data}

  always #5 clk = ~clk;

  muldiv_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .unit_op1_o(unit_op1_o), .unit_op2_o(unit_op2_o), .unit_op_o(unit_op_o),
    .unit_wdata_i(unit_wdata_i), .unit_we_i(unit_we_i)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  opc0, opc1;
    logic [31:0] a0, b0, a1, b1;
    int          delay;      // -1 illegal op, >=TO no unit completion
    logic [1:0]  exp_ready;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        spur;       // unit_we pulses in the IDLE handshake and RESP cycles
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
    req_valid_i = v;
    req_op_i    = {o1, o0};
    req_op1_i   = {a1, a0};
    req_op2_i   = {b1, b0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_resp_data"}, resp_data_o, 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err_o), 32'd0);
    check({tag, "_unit_op"}, 32'(unit_op_o), 32'd0);
    check({tag, "_unit_op1"}, unit_op1_o, 32'd0);
    check({tag, "_unit_op2"}, unit_op2_o, 32'd0);
  endtask

  task automatic check_resp();
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty act=0 exp=1");
    end else begin
      e = exp_q.pop_front();
      check("resp_valid", 32'(resp_valid_o), 32'(1) << e[33]);
      check("resp_data", resp_data_o, e[31:0]);
      check("resp_err", 32'(resp_err_o), 32'(e[32]));
    end
  endtask

  // Called in an IDLE cycle at posedge+1; returns in the following IDLE cycle.
  task automatic run_vec(input vec_t v);
    logic        g;
    logic [7:0]  gop;
    logic [31:0] ga, gb;
    int          last;
    set_req(v.valid, v.opc0, v.opc1, v.a0, v.b0, v.a1, v.b1);
    unit_we_i    = v.spur;
    unit_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("grant", 32'(req_ready_o), 32'(v.exp_ready));
    g   = v.exp_ready[1];
    gop = g ? v.opc1 : v.opc0;
    ga  = g ? v.a1 : v.a0;
    gb  = g ? v.b1 : v.b0;
    exp_q.push_back({g, v.exp_err, v.exp_data});
    step();
    if (v.delay < 0) begin
      unit_we_i = 1'b0;
      check("illegal_unit_op", 32'(unit_op_o), 32'd0);
      check("illegal_unit_op1", unit_op1_o, 32'd0);
      check("illegal_ready", 32'(req_ready_o), 32'd0);
      check("illegal_early_resp", 32'(resp_valid_o), 32'd0);
      step();
    end else begin
      last = (v.delay >= TO) ? TO - 1 : v.delay;
      for (int c = 0; c <= last; c++) begin
        unit_we_i    = (c == v.delay);
        unit_wdata_i = (c == v.delay) ? v.exp_data : 32'hDEAD_BEEF;
        check("busy_unit_op", 32'(unit_op_o), 32'(gop));
        check("busy_unit_op1", unit_op1_o, ga);
        check("busy_unit_op2", unit_op2_o, gb);
        check("busy_ready", 32'(req_ready_o), 32'd0);
        check("busy_resp", 32'(resp_valid_o), 32'd0);
        step();
      end
    end
    unit_we_i    = v.spur;
    unit_wdata_i = 32'hDEAD_BEEF;
    check_resp();
    check("resp_unit_op", 32'(unit_op_o), 32'd0);
    check("resp_ready", 32'(req_ready_o), 32'd0);
    step();
    unit_we_i = 1'b0;
    check("idle_resp_valid", 32'(resp_valid_o), 32'd0);
    check("idle_resp_data", resp_data_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    //          valid  opc0   opc1   a0             b0      a1             b1      delay   ready  data            err  spur
    vecs[0]  = '{2'b11, 8'h80, 8'h80, 32'd7,         32'd6,  32'd3,         32'd5,  2,      2'b10, 32'd15,         1'b0, 1'b0};
    vecs[1]  = '{2'b01, 8'h80, 8'h80, 32'd7,         32'd6,  32'd3,         32'd5,  1,      2'b01, 32'd42,         1'b0, 1'b0};
    vecs[2]  = '{2'b11, 8'h08, 8'h08, 32'hFFFFFF9C,  32'd7,  32'hFFFFFF9C,  32'd7,  3,      2'b10, 32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[3]  = '{2'b11, 8'h08, 8'h08, 32'hFFFFFF9C,  32'd7,  32'hFFFFFF9C,  32'd7,  0,      2'b01, 32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[4]  = '{2'b11, 8'h08, 8'h08, 32'hFFFFFF9C,  32'd7,  32'hFFFFFF9C,  32'd7,  2,      2'b10, 32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[5]  = '{2'b11, 8'h08, 8'h08, 32'hFFFFFF9C,  32'd7,  32'hFFFFFF9C,  32'd7,  5,      2'b01, 32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[6]  = '{2'b10, 8'h80, 8'h0C, 32'd1,         32'd2,  32'd11,        32'd12, -1,     2'b10, 32'd0,          1'b1, 1'b1};
    vecs[7]  = '{2'b11, 8'h00, 8'h10, 32'd1,         32'd2,  32'd3,         32'd4,  -1,     2'b01, 32'd0,          1'b1, 1'b0};
    vecs[8]  = '{2'b11, 8'h01, 8'h02, 32'd17,        32'd5,  32'hFFFFFFEF,  32'd5,  4,      2'b10, 32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[9]  = '{2'b01, 8'h01, 8'h02, 32'd17,        32'd5,  32'hFFFFFFEF,  32'd5,  0,      2'b01, 32'd2,          1'b0, 1'b1};
    vecs[10] = '{2'b01, 8'h80, 8'h80, 32'd9,         32'd9,  32'd1,         32'd1,  TO,     2'b01, 32'd0,          1'b1, 1'b0};
    vecs[11] = '{2'b11, 8'h80, 8'h20, 32'd9,         32'd9,  32'h40000000,  32'd4,  TO - 1, 2'b10, 32'd1,          1'b0, 1'b0};
    vecs[12] = '{2'b11, 8'h04, 8'h04, 32'd100,       32'd0,  32'd100,       32'd0,  1,      2'b01, 32'hFFFFFFFF,   1'b0, 1'b0};

    rst          = 1'b1;
    unit_we_i    = 1'b0;
    unit_wdata_i = '0;
    set_req(2'b11, 8'h80, 8'h80, 32'd1, 32'd2, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Unit completions with nothing in flight must not produce a response.
    set_req(2'b00, 8'h80, 8'h80, 32'd0, 32'd0, 32'd0, 32'd0);
    unit_we_i    = 1'b1;
    unit_wdata_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spur_idle_resp", 32'(resp_valid_o), 32'd0);
      check("spur_idle_ready", 32'(req_ready_o), 32'd0);
    end
    unit_we_i = 1'b0;
    set_req(2'b01, 8'h80, 8'h80, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    check("spur_idle_still_idle", 32'(req_ready_o), 32'd1);
    set_req(2'b00, 8'h80, 8'h80, 32'd0, 32'd0, 32'd0, 32'd0);
    step();

    // Reset while BUSY: outputs drop at once, no response, pointer back to 0.
    set_req(2'b10, 8'h80, 8'h80, 32'd0, 32'd0, 32'd2, 32'd3);
    #1;
    check("pre_reset_grant", 32'(req_ready_o), 32'd2);
    step();
    check("pre_reset_unit_op", 32'(unit_op_o), 32'h80);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    step();
    check_all_zero("mid_reset_edge");
    rst = 1'b0;
    run_vec('{2'b11, 8'h80, 8'h80, 32'd7, 32'd6, 32'd2, 32'd3, 1, 2'b10, 32'd6, 1'b0, 1'b0});
    set_req(2'b00, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    check("final_idle_resp", 32'(resp_valid_o), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
